// File: rtl/sobol_pair_consumer.sv
`default_nettype none
// ============================================================================
//  Module   : sobol_pair_consumer
//  Purpose  : Reader side of the packed 2-D Sobol stream. Each 32-bit sample
//             carries x in [31:16] and y in [15:0], both unsigned Q0.16. The
//             block takes a programmed number of samples over valid/ready.
//             It counts the samples that fall strictly inside the unit quarter
//             circle (x^2 + y^2 < 1.0, i.e. < 2^32 in raw units).
//  Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//             start, n_samples    - begin a run of n_samples (ignored if busy)
//             in_valid, in_data   - upstream sample handshake / packed sample
//             in_ready            - sample accepted on in_valid && in_ready
//             busy                - run in progress (RUN or DRAIN)
//             done                - one-cycle pulse when counts are final
//             sample_count        - samples accepted in current/last run
//             hit_count           - in-circle samples in current/last run
//  Revision : 1.0 - initial release
// ============================================================================
module sobol_pair_consumer #(
   parameter int NW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [NW-1:0] n_samples,
   input  logic          in_valid,
   input  logic [31:0]   in_data,
   output logic          in_ready,
   output logic          busy,
   output logic          done,
   output logic [NW-1:0] sample_count,
   output logic [NW-1:0] hit_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [NW-1:0] r_target;
   logic [NW-1:0] r_sample_count;
   logic [NW-1:0] r_hit_count;
   logic          r_done;
   logic          w_enter_done;
   logic          w_start_ok;
   logic          w_xfer;
   logic          w_last;

   // Squaring pipeline: stage 1 holds the squares, stage 2 holds the hit flag.
   logic          r_v1;
   logic          r_v2;
   logic          r_hit2;
   logic [31:0]   r_xsq;
   logic [31:0]   r_ysq;
   logic [31:0]   w_x;
   logic [31:0]   w_y;
   logic [32:0]   w_sum;

   assign w_x        = {16'd0, in_data[31:16]};
   assign w_y        = {16'd0, in_data[15:0]};
   assign w_sum      = {1'b0, r_xsq} + {1'b0, r_ysq};

   assign in_ready   = (r_state == S_RUN) && (r_sample_count < r_target);
   assign w_xfer     = in_valid && in_ready;
   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   // Count is strictly below target whenever a transfer happens, so +1 cannot wrap.
   assign w_last     = w_xfer && ((r_sample_count + NW'(1)) == r_target);

   always_comb begin
      w_next       = r_state;
      w_enter_done = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_start_ok) begin
               if (n_samples != '0) begin
                  w_next = S_RUN;
               end else begin
                  // Empty run completes immediately with zero counts.
                  w_next       = S_DONE;
                  w_enter_done = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // hit_count is final only once both pipeline stages have emptied.
            if (!r_v1 && !r_v2) begin
               w_next       = S_DONE;
               w_enter_done = 1'b1;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_done         <= 1'b0;
         r_target       <= '0;
         r_sample_count <= '0;
         r_hit_count    <= '0;
         r_v1           <= 1'b0;
         r_v2           <= 1'b0;
         r_hit2         <= 1'b0;
         r_xsq          <= '0;
         r_ysq          <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= w_enter_done;

         r_v1 <= w_xfer;
         if (w_xfer) begin
            r_xsq <= w_x * w_x;
            r_ysq <= w_y * w_y;
         end
         r_v2   <= r_v1;
         // Bit 32 set means the sum reached 2^32 or more: outside (or on) the circle.
         r_hit2 <= r_v1 && !w_sum[32];

         if (w_start_ok) begin
            r_target       <= n_samples;
            r_sample_count <= '0;
            r_hit_count    <= '0;
         end else begin
            if (w_xfer) begin
               r_sample_count <= r_sample_count + NW'(1);
            end
            if (r_v2 && r_hit2) begin
               r_hit_count <= r_hit_count + NW'(1);
            end
         end
      end
   end

   assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done         = r_done;
   assign sample_count = r_sample_count;
   assign hit_count    = r_hit_count;

endmodule
`default_nettype wire
